byteblast8_loader: RTL and testbench

Program loader for the byteblast8 core: accepts a byte stream over a valid/ready handshake and writes it into the shared program/data RAM, the write-side counterpart to the fetch/decode/execute path that reads RAM. While loading it holds the `fde` sequencer disabled. When `VERIFY=1` it re-reads the loaded region and compares an 8-bit checksum before releasing the core. It sits between the external host link and the RAM write port, and drives the `fde` enable.

---
 rtl/byteblast8_loader.sv | 161 ++++++++++++++++
 tb/tb_byteblast8_loader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byteblast8_loader.sv
// Program loader: streams host bytes into the shared RAM, optionally verifies an 8-bit checksum, then enables the core.
// Latency: start->in_ready 1 cycle; accept->ram_we 1 cycle; last accept->done 2 cycles (VERIFY=0) or 2*(count+1)+2 cycles (VERIFY=1).
// Backpressure: in_ready is high only while loading; in_valid and start are ignored whenever they cannot be taken.
//
// Ports:
//   clk, reset (async, active-low)
//   start/base/count : load request, sampled only when idle
//   in_valid/in_ready/in_data : host byte handshake
//   ram_we/ram_adr/ram_din/ram_dout : RAM port (registered read, dout one cycle after adr)
//   cpu_enable : fde sequencer enable; busy/done/error : status
module byteblast8_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int VERIFY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] count,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_adr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              cpu_enable,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_VADDR,
        S_VCMP,
        S_FINISH
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_wsum;
    logic [DATA_W-1:0] r_rsum;
    logic              r_rd_pend;
    logic              r_in_ready;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_adr;
    logic [DATA_W-1:0] r_ram_din;
    logic              r_cpu_enable;
    logic              r_busy;
    logic              r_done;
    logic              r_error;

    // Read-back total including the byte landing on ram_dout this cycle;
    // width keeps the sum modulo 2^DATA_W.
    logic [DATA_W-1:0] w_rsum_final;
    assign w_rsum_final = r_rsum + ram_dout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_count      <= '0;
            r_idx        <= '0;
            r_wsum       <= '0;
            r_rsum       <= '0;
            r_rd_pend    <= 1'b0;
            r_in_ready   <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_adr    <= '0;
            r_ram_din    <= '0;
            r_cpu_enable <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_ram_we <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base       <= base;
                        r_count      <= count;
                        r_idx        <= '0;
                        r_wsum       <= '0;
                        r_rsum       <= '0;
                        r_rd_pend    <= 1'b0;
                        r_cpu_enable <= 1'b0;
                        r_error      <= 1'b0;
                        r_in_ready   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid && r_in_ready) begin
                        r_ram_we  <= 1'b1;
                        r_ram_adr <= r_base + r_idx;
                        r_ram_din <= in_data;
                        r_wsum    <= r_wsum + in_data;
                        if (r_idx == r_count) begin
                            r_idx      <= '0;
                            r_in_ready <= 1'b0;
                            r_state    <= (VERIFY != 0) ? S_VADDR : S_FINISH;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                S_VADDR: begin
                    // The RAM captures the address at the end of VCMP, so the
                    // word for the previous index shows up here; fold it in now.
                    r_ram_adr <= r_base + r_idx;
                    if (r_rd_pend) begin
                        r_rsum <= w_rsum_final;
                    end
                    r_rd_pend <= 1'b0;
                    r_state   <= S_VCMP;
                end
                S_VCMP: begin
                    r_rd_pend <= 1'b1;
                    if (r_idx == r_count) begin
                        r_state <= S_FINISH;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= S_VADDR;
                    end
                end
                S_FINISH: begin
                    // With VERIFY the last read word is on ram_dout this cycle.
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if ((VERIFY != 0) && (w_rsum_final != r_wsum)) begin
                        r_error      <= 1'b1;
                        r_cpu_enable <= 1'b0;
                    end else begin
                        r_cpu_enable <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign ram_we     = r_ram_we;
    assign ram_adr    = r_ram_adr;
    assign ram_din    = r_ram_din;
    assign cpu_enable = r_cpu_enable;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_byteblast8_loader.sv
// Bench for byteblast8_loader: two instances (VERIFY=1 and VERIFY=0) share one RAM model,
// selected by sel. A cycle-level behavioural model predicts every output; directed
// tests add literal expectations on RAM contents, write counts and done latency.
module tb_byteblast8_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [4:0] base_i = '0;
    logic [4:0] count_i = '0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       sel = 1'b0;

    logic       in_ready0, we0, cpu0, busy0, done0, err0;
    logic [4:0] adr0;
    logic [7:0] din0;
    logic       in_ready1, we1, cpu1, busy1, done1, err1;
    logic [4:0] adr1;
    logic [7:0] din1;
    logic [7:0] ram_dout;

    logic       start0, start1, valid0, valid1;
    assign start0 = start & ~sel;
    assign start1 = start & sel;
    assign valid0 = in_valid & ~sel;
    assign valid1 = in_valid & sel;

    byteblast8_loader #(.ADDR_W(5), .DATA_W(8), .VERIFY(1)) u_dut_v (
        .clk(clk), .reset(reset), .start(start0), .base(base_i), .count(count_i),
        .in_valid(valid0), .in_data(in_data), .in_ready(in_ready0),
        .ram_we(we0), .ram_adr(adr0), .ram_din(din0), .ram_dout(ram_dout),
        .cpu_enable(cpu0), .busy(busy0), .done(done0), .error(err0)
    );

    byteblast8_loader #(.ADDR_W(5), .DATA_W(8), .VERIFY(0)) u_dut_nv (
        .clk(clk), .reset(reset), .start(start1), .base(base_i), .count(count_i),
        .in_valid(valid1), .in_data(in_data), .in_ready(in_ready1),
        .ram_we(we1), .ram_adr(adr1), .ram_din(din1), .ram_dout(ram_dout),
        .cpu_enable(cpu1), .busy(busy1), .done(done1), .error(err1)
    );

    logic       w_in_ready, w_we, w_cpu, w_busy, w_done, w_err;
    logic [4:0] w_adr;
    logic [7:0] w_din;
    assign w_in_ready = sel ? in_ready1 : in_ready0;
    assign w_we       = sel ? we1 : we0;
    assign w_adr      = sel ? adr1 : adr0;
    assign w_din      = sel ? din1 : din0;
    assign w_cpu      = sel ? cpu1 : cpu0;
    assign w_busy     = sel ? busy1 : busy0;
    assign w_done     = sel ? done1 : done0;
    assign w_err      = sel ? err1 : err0;

    always #5 clk = ~clk;

    // Shared RAM with registered read; corrupt_en overwrites location 2.
    logic [7:0] mem [0:31];
    logic       corrupt_en = 1'b0;
    always @(posedge clk) begin
        if (corrupt_en) mem[2] <= 8'hFF;
        if (w_we) mem[w_adr] <= w_din;
        ram_dout <= mem[w_adr];
    end

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Behavioural model: cyc is the cycle just entered at this edge; inputs seen
    // here belong to cycle cyc-1. Expected outputs are held in e_*.
    logic       e_in_ready, e_we, e_cpu, e_busy, e_done, e_err;
    int         e_adr, e_din;
    int         m_base, m_n, m_k, c0, done_cyc, wsum;
    bit         m_ver, m_verifying;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc = 0;
            e_in_ready = 0; e_we = 0; e_cpu = 0; e_busy = 0; e_done = 0; e_err = 0;
            e_adr = 0; e_din = 0;
            m_base = 0; m_n = 0; m_k = 0; c0 = 0; done_cyc = -1; wsum = 0;
            m_ver = 0; m_verifying = 0;
        end else begin
            cyc = cyc + 1;
            e_we = 0;
            e_done = 0;
            if (start && !e_busy) begin
                m_base = int'(base_i); m_n = int'(count_i); m_k = 0; wsum = 0;
                m_ver = !sel;
                e_in_ready = 1; e_busy = 1; e_cpu = 0; e_err = 0;
            end else if (e_in_ready && in_valid) begin
                e_we = 1;
                e_adr = (m_base + m_k) % 32;
                e_din = int'(in_data);
                wsum = wsum + int'(in_data);
                if (m_k == m_n) begin
                    e_in_ready = 0;
                    c0 = cyc - 1;
                    done_cyc = m_ver ? c0 + 2 * (m_n + 1) + 2 : c0 + 2;
                    m_verifying = m_ver;
                end
                m_k = m_k + 1;
            end
            // Each verified address is on the port for two cycles.
            if (m_verifying && cyc >= c0 + 2 && cyc < done_cyc)
                e_adr = (m_base + (cyc - c0 - 2) / 2) % 32;
            if (cyc == done_cyc) begin
                int rs;
                bit bad;
                rs = 0;
                for (int j = 0; j <= m_n; j++) rs = rs + int'(mem[(m_base + j) % 32]);
                bad = m_ver && ((rs % 256) != (wsum % 256));
                e_done = 1; e_busy = 0; e_err = bad; e_cpu = !bad;
                m_verifying = 0;
            end
        end
    end

    bit chk_en = 1'b0;
    int wr_cnt = 0;
    always @(negedge clk) begin
        if (reset && chk_en) begin
            chk("in_ready", w_in_ready, e_in_ready);
            chk("ram_we", w_we, e_we);
            chk("ram_adr", w_adr, e_adr);
            chk("ram_din", w_din, e_din);
            chk("busy", w_busy, e_busy);
            chk("done", w_done, e_done);
            chk("cpu_enable", w_cpu, e_cpu);
            chk("error", w_err, e_err);
            if (w_we) wr_cnt++;
        end
    end

    logic [7:0] stim [0:31];
    int last_acc = 0;
    int done_at = 0;

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, w_in_ready, 0);
        chk({tag, "_ram_we"}, w_we, 0);
        chk({tag, "_ram_adr"}, w_adr, 0);
        chk({tag, "_ram_din"}, w_din, 0);
        chk({tag, "_cpu_enable"}, w_cpu, 0);
        chk({tag, "_busy"}, w_busy, 0);
        chk({tag, "_done"}, w_done, 0);
        chk({tag, "_error"}, w_err, 0);
    endtask

    task automatic run_load(input int b, input int n, input bit thr,
                            input int abort_after, input int glitch_at, input bit corrupt);
        int k, guard;
        bit acc, tog;
        @(negedge clk);
        start = 1; base_i = b[4:0]; count_i = n[4:0]; in_valid = 0;
        @(negedge clk);
        start = 0;
        k = 0; tog = 1; guard = 0;
        while (k <= n && guard < 400) begin
            if (abort_after >= 0 && k == abort_after) begin
                in_valid = 0;
                reset = 0;
                #1;
                check_reset_vals("midrst");
                @(negedge clk);
                reset = 1;
                return;
            end
            in_valid = thr ? tog : 1'b1;
            tog = !tog;
            in_data = stim[k];
            if (k == glitch_at) begin
                start = 1;
                base_i = 5'd3;
            end
            acc = in_valid && w_in_ready;
            if (acc && k == n) last_acc = cyc;
            @(negedge clk);
            start = 0;
            if (acc) k++;
            guard++;
        end
        in_valid = 0;
        if (k <= n) chk("load_timeout", k, n + 1);
        if (corrupt) begin
            corrupt_en = 1;
            @(negedge clk);
            corrupt_en = 0;
        end
    endtask

    task automatic wait_done(input string tag);
        int g;
        g = 0;
        while (!w_done && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!w_done) chk({tag, "_done_timeout"}, 0, 1);
        done_at = cyc;
    endtask

    initial begin
        int w0;
        reset = 0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1;
        chk_en = 1;
        @(negedge clk);

        // 1: basic load, VERIFY=1
        stim[0] = 8'h23; stim[1] = 8'h44; stim[2] = 8'h85;
        stim[3] = 8'h02; stim[4] = 8'h05; stim[5] = 8'h00;
        w0 = wr_cnt;
        run_load(0, 5, 0, -1, -1, 0);
        wait_done("t1");
        chk("t1_done_latency", done_at - last_acc, 14);
        chk("t1_error", w_err, 0);
        chk("t1_cpu_enable", w_cpu, 1);
        chk("t1_mem0", mem[0], 8'h23);
        chk("t1_mem2", mem[2], 8'h85);
        chk("t1_mem5", mem[5], 8'h00);
        @(negedge clk);
        chk("t1_writes", wr_cnt - w0, 6);

        // 2: address wrap
        for (int i = 0; i < 4; i++) stim[i] = 8'hA1 + 8'(i);
        run_load(30, 3, 0, -1, -1, 0);
        wait_done("t2");
        chk("t2_done_latency", done_at - last_acc, 10);
        chk("t2_error", w_err, 0);
        chk("t2_mem30", mem[30], 8'hA1);
        chk("t2_mem31", mem[31], 8'hA2);
        chk("t2_mem0", mem[0], 8'hA3);
        chk("t2_mem1", mem[1], 8'hA4);

        // 3: throttled host
        for (int i = 0; i < 5; i++) stim[i] = 8'h11 * 8'(i + 1);
        w0 = wr_cnt;
        run_load(8, 4, 1, -1, -1, 0);
        wait_done("t3");
        @(negedge clk);
        chk("t3_writes", wr_cnt - w0, 5);
        chk("t3_mem8", mem[8], 8'h11);
        chk("t3_mem12", mem[12], 8'h55);

        // 4: verify failure (location 2 corrupted before read-back)
        for (int i = 0; i < 6; i++) stim[i] = 8'h10 * 8'(i + 1);
        run_load(0, 5, 0, -1, -1, 1);
        wait_done("t4");
        chk("t4_done", w_done, 1);
        chk("t4_error", w_err, 1);
        chk("t4_cpu_enable", w_cpu, 0);
        @(negedge clk);

        // 5: in_valid in IDLE ignored, start during LOAD ignored, error cleared
        w0 = wr_cnt;
        in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_idle_in_ready", w_in_ready, 0);
        end
        in_valid = 0;
        chk("t5_idle_writes", wr_cnt - w0, 0);
        stim[0] = 8'h07; stim[1] = 8'h08; stim[2] = 8'h09;
        run_load(16, 2, 0, -1, 1, 0);
        wait_done("t5");
        chk("t5_error_cleared", w_err, 0);
        chk("t5_cpu_enable", w_cpu, 1);
        @(negedge clk);
        chk("t5_writes", wr_cnt - w0, 3);
        chk("t5_mem17", mem[17], 8'h08);
        chk("t5_mem3_untouched", mem[3], 8'h40);

        // 6: reset after 3 accepts, then full fill on the VERIFY=0 instance
        for (int i = 0; i < 8; i++) stim[i] = 8'hC0 + 8'(i);
        run_load(4, 10, 0, 3, -1, 0);
        chk("t6_partial_mem5", mem[5], 8'hC1);
        @(negedge clk);
        sel = 1;
        for (int i = 0; i < 32; i++) stim[i] = 8'(i * 7 + 3);
        w0 = wr_cnt;
        run_load(0, 31, 0, -1, -1, 0);
        wait_done("t6");
        chk("t6_done_latency", done_at - last_acc, 2);
        chk("t6_cpu_enable", w_cpu, 1);
        @(negedge clk);
        chk("t6_writes", wr_cnt - w0, 32);
        for (int i = 0; i < 32; i++) chk("t6_mem", mem[i], (i * 7 + 3) % 256);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL global_timeout: got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
